// File: rtl/pixel_colour_pkg.sv
// Shared constants and reset palette for the pixel colour stage.
// Colours are packed {R,G,B}, R in the most significant field.
package pixel_colour_pkg;

    localparam int FLASH_W         = 8;
    localparam int NUM_CHANNELS    = 3;
    localparam int MAX_COLOUR_BITS = 4;
    localparam int MAX_COLOUR_W    = NUM_CHANNELS * MAX_COLOUR_BITS;

    function automatic int colour_w(input int cb);
        return NUM_CHANNELS * cb;
    endfunction

    function automatic logic [MAX_COLOUR_W-1:0] chan_ones(input int cb);
        return MAX_COLOUR_W'((1 << cb) - 1);
    endfunction

    function automatic logic [MAX_COLOUR_W-1:0] reset_fg(input int cb);
        return MAX_COLOUR_W'((1 << (NUM_CHANNELS * cb)) - 1);
    endfunction

    // Entry 0 red, 1 green, 2 blue, 3 magenta, the rest black.
    function automatic logic [MAX_COLOUR_W-1:0] reset_bg(
        input int idx,
        input int cb
    );
        logic [MAX_COLOUR_W-1:0] w_ones;
        w_ones = chan_ones(cb);
        case (idx)
            0:       return w_ones << (2 * cb);
            1:       return w_ones << cb;
            2:       return w_ones;
            3:       return (w_ones << (2 * cb)) | w_ones;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth register delay line with synchronous clear.
// Used to keep colour and sync aligned through the output pipe.
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the data one stage per clock; reset clears every stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/pixel_colour_stage.sv
// Palette lookup, flash inversion and aligned output pipeline.
// Palette changes take effect only at frame boundaries.
module pixel_colour_stage
    import pixel_colour_pkg::*;
#(
    parameter int COLOUR_BITS  = 2,
    parameter int NUM_PALETTES = 4,
    parameter int PIPE_STAGES  = 1,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            pixel_value,
    input  logic                            video_active,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic                            frame_end,
    input  logic [$clog2(NUM_PALETTES)-1:0] palette_sel,
    input  logic                            pal_wr_en,
    input  logic [$clog2(NUM_PALETTES)-1:0] pal_wr_idx,
    input  logic [3*COLOUR_BITS-1:0]        pal_wr_fg,
    input  logic [3*COLOUR_BITS-1:0]        pal_wr_bg,
    input  logic                            flash_trigger,
    output logic [COLOUR_BITS-1:0]          R,
    output logic [COLOUR_BITS-1:0]          G,
    output logic [COLOUR_BITS-1:0]          B,
    output logic                            hsync_out,
    output logic                            vsync_out,
    output logic                            flash_active
);

    localparam int CW    = colour_w(COLOUR_BITS);
    localparam int SEL_W = $clog2(NUM_PALETTES);
    localparam int PW    = CW + 2;

    logic [CW-1:0]      r_shadow_fg [NUM_PALETTES];
    logic [CW-1:0]      r_shadow_bg [NUM_PALETTES];
    logic [CW-1:0]      r_active_fg [NUM_PALETTES];
    logic [CW-1:0]      r_active_bg [NUM_PALETTES];
    logic [SEL_W-1:0]   r_sel;
    logic [FLASH_W-1:0] r_flash_cnt;

    logic               w_flash_active;
    logic               w_use_fg;
    logic [CW-1:0]      w_fg;
    logic [CW-1:0]      w_bg;
    logic [CW-1:0]      w_colour;
    logic [PW-1:0]      w_pipe_in;
    logic [PW-1:0]      w_pipe_out;

    // Shadow bank takes writes at once; active bank refreshes at frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PALETTES; i++) begin
                r_shadow_fg[i] <= CW'(reset_fg(COLOUR_BITS));
                r_shadow_bg[i] <= CW'(reset_bg(i, COLOUR_BITS));
                r_active_fg[i] <= CW'(reset_fg(COLOUR_BITS));
                r_active_bg[i] <= CW'(reset_bg(i, COLOUR_BITS));
            end
        end else begin
            if (pal_wr_en) begin
                r_shadow_fg[pal_wr_idx] <= pal_wr_fg;
                r_shadow_bg[pal_wr_idx] <= pal_wr_bg;
            end
            if (frame_end) begin
                for (int i = 0; i < NUM_PALETTES; i++) begin
                    if (pal_wr_en && pal_wr_idx == SEL_W'(i)) begin
                        r_active_fg[i] <= pal_wr_fg;
                        r_active_bg[i] <= pal_wr_bg;
                    end else begin
                        r_active_fg[i] <= r_shadow_fg[i];
                        r_active_bg[i] <= r_shadow_bg[i];
                    end
                end
            end
        end
    end

    // Latch the requested palette only at the frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel <= '0;
        end else if (frame_end) begin
            r_sel <= palette_sel;
        end
    end

    // Flash frame counter: trigger reloads, frame end counts down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flash_cnt <= '0;
        end else if (flash_trigger) begin
            r_flash_cnt <= FLASH_W'(FLASH_FRAMES);
        end else if (frame_end && r_flash_cnt != '0) begin
            r_flash_cnt <= r_flash_cnt - FLASH_W'(1);
        end
    end

    assign w_flash_active = (r_flash_cnt != '0);
    assign w_fg           = r_active_fg[r_sel];
    assign w_bg           = r_active_bg[r_sel];
    assign w_use_fg       = pixel_value ^ w_flash_active;
    assign w_colour       = video_active ? (w_use_fg ? w_fg : w_bg)
                                         : '0;
    assign w_pipe_in      = {hsync_in, vsync_in, w_colour};

    sync_delay_line #(
        .WIDTH (PW),
        .DEPTH (PIPE_STAGES)
    ) u_delay (
        .clk    (clk),
        .reset  (reset),
        .i_data (w_pipe_in),
        .o_data (w_pipe_out)
    );

    assign hsync_out    = w_pipe_out[CW+1];
    assign vsync_out    = w_pipe_out[CW];
    assign R            = w_pipe_out[CW-1 -: COLOUR_BITS];
    assign G            = w_pipe_out[2*COLOUR_BITS-1 -: COLOUR_BITS];
    assign B            = w_pipe_out[COLOUR_BITS-1:0];
    assign flash_active = w_flash_active;

endmodule

// File: doc/pixel_colour_stage.md
PIXEL_COLOUR_STAGE -- requirements
Module: pixel_colour_stage

Interface
REQ-001 SHALL have parameter COLOUR_BITS, default 2, bits per colour channel (1..4).
REQ-002 SHALL have parameter NUM_PALETTES, default 4, number of palette entries (2..16, power of two).
REQ-003 SHALL have parameter PIPE_STAGES, default 1, output latency in cycles (1..4).
REQ-004 SHALL have parameter FLASH_FRAMES, default 8, frames of colour inversion per flash (0 disables; max 255).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port pixel_value  input  1  foreground (1) / background (0) from the picture processing unit.
REQ-008 SHALL have port video_active  input  1  visible-area flag from the sync generator.
REQ-009 SHALL have ports hsync_in, vsync_in  input  1 each  raw sync from the sync generator.
REQ-010 SHALL have port frame_end  input  1  one-cycle end-of-frame pulse.
REQ-011 SHALL have port palette_sel  input  log2(NUM_PALETTES)  requested palette (e.g. player direction).
REQ-012 SHALL have ports pal_wr_en (1), pal_wr_idx (log2(NUM_PALETTES)), pal_wr_fg and pal_wr_bg (3*COLOUR_BITS, packed {R,G,B})  inputs  palette write port.
REQ-013 SHALL have port flash_trigger  input  1  start/restart flash effect.
REQ-014 SHALL have ports R, G, B  output  COLOUR_BITS each  registered colour; hsync_out, vsync_out  output  1 each  delayed sync; flash_active  output  1  flash counter nonzero.

Function
REQ-015 SHALL hold two palette banks: shadow (written by pal_wr_en on the same edge) and active (used for rendering).
REQ-016 SHALL copy every shadow entry to active, and sample palette_sel into a selected-palette register, on the cycle frame_end=1; no mid-frame colour change.
REQ-017 SHALL, on pal_wr_en and frame_end in the same cycle, copy the newly written value into active (write-through for that entry).
REQ-018 SHALL compute colour = video_active ? (pixel_value ^ flash_active ? fg : bg of selected active palette) : all zeros.
REQ-019 SHALL delay colour, hsync_in and vsync_in by exactly PIPE_STAGES cycles through identical registers, keeping sync and colour aligned.
REQ-020 SHALL implement a flash counter (8 bits): flash_trigger loads FLASH_FRAMES; each frame_end with counter>0 decrements by 1; saturates at 0.
REQ-021 SHALL give flash_trigger priority over decrement when both occur in one cycle; retrigger while active reloads FLASH_FRAMES.
REQ-022 SHALL keep flash_active=0 permanently when FLASH_FRAMES=0.
REQ-023 SHALL ignore palette_sel values >= NUM_PALETTES impossible by width; no further range check required.

Reset
REQ-024 SHALL set R, G, B, hsync_out, vsync_out, all pipeline registers, flash counter and selected palette to 0 on reset.
REQ-025 SHALL reset both banks: every fg = all-ones; bg of entry 0 = red, 1 = green, 2 = blue, 3 = magenta (channel all-ones), entries >=4 = black.
REQ-026 SHALL abandon any flash and any pending shadow writes when reset asserts mid-frame.

Structure
REQ-027 SHALL place reset palette table, packed-colour field widths and flash counter width in a shared package/include.
REQ-028 SHALL use one sub-module, sync_delay_line (parameterised width and depth), for the colour/sync pipeline.

Verification
REQ-029 SHALL cover: reset, video_active=1, pixel_value=0, palette_sel=0 held, frame_end -> after PIPE_STAGES cycles R=3,G=0,B=0.
REQ-030 SHALL cover: pal_wr_en idx1 bg={1,2,3} mid-frame with palette_sel=1 -> output unchanged until cycle after frame_end, then bg R=1,G=2,B=3.
REQ-031 SHALL cover: flash_trigger with FLASH_FRAMES=8 -> fg/bg swapped for 8 frame_end pulses, flash_active falls on the 8th.
REQ-032 SHALL cover: flash_trigger coincident with frame_end at counter=3 -> counter=8, not 2.
REQ-033 SHALL cover: video_active=0, pixel_value=1 -> RGB=0 while hsync_out/vsync_out equal inputs delayed PIPE_STAGES cycles (check PIPE_STAGES=1 and 3).
REQ-034 SHALL cover: reset asserted during flash with modified shadow -> flash_active=0, palettes back to REQ-025 defaults next cycle.
